mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Parametrised MEM→WB pipeline register for the MIPS core. It carries NCH independent register-write channels (channel 0 = GPR file, higher channels = HI/LO or CP0), each with its own address, enable and data. Compared with the fixed single-channel stage, it adds stall/flush control using the core's stall-vector convention, bubble insertion, a valid bit, and a retired-instruction counter. It sits between the MEM stage and the register files, and also drives the WB-stage forwarding taps.

Parameters:
DW, 32, data width per channel
AW, 5, register address width per channel
NCH, 2, number of write channels (≥1)
CNTW, 32, retired-instruction counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (0 = reset)
mem_valid  in  1  MEM stage holds a real instruction
mem_wd  in  NCH*AW  per-channel destination address, channel k at [k*AW +: AW]
mem_wreg  in  NCH  per-channel write enable
mem_wdata  in  NCH*DW  per-channel write data
stall_mem  in  1  MEM stage stalled (stall vector bit for MEM)
stall_wb  in  1  WB stage stalled (stall vector bit for WB)
flush  in  1  exception/eret flush
wb_valid  out  1  WB holds a real instruction
wb_wd  out  NCH*AW  registered addresses
wb_wreg  out  NCH  registered enables, already gated by wb_valid
wb_wdata  out  NCH*DW  registered data
retired  out  CNTW  count of instructions that left WB
cnt_clr  in  1  synchronous clear of retired

Behaviour:
- All state updates on posedge clk. Latency is 1 cycle from the MEM inputs to the WB outputs.
- Reset (rst==0) has highest priority:
  - wb_valid=0, wb_wd=0, wb_wreg=0, wb_wdata=0, retired=0.
  - Reset applied mid-operation discards the in-flight entry.
- Priority after reset is flush > stall/bubble > advance.
- flush==1:
  - wb_valid=0, wb_wreg=0, wb_wd=0, wb_wdata=0.
  - Overrides stall_wb.
- stall_mem==1 and stall_wb==0 (bubble):
  - wb_valid=0 and wb_wreg=0.
  - wb_wd and wb_wdata are cleared to 0.
- stall_wb==1, no flush: all wb_* outputs hold their values.
- Otherwise (advance):
  - wb_valid<=mem_valid.
  - wb_wreg<=mem_wreg & {NCH{mem_valid}}.
  - wb_wd<=mem_wd and wb_wdata<=mem_wdata, per channel unchanged.
- Channels are fully independent. Several channels may be enabled in the same cycle, and there is no arbitration.
- retired counter:
  - Increments by 1 on each edge where the current wb_valid==1 and stall_wb==0 (the instruction leaves WB).
  - cnt_clr has priority over increment.
  - Wraps modulo 2^CNTW; no saturation.
  - A flush does not block the increment of the instruction currently leaving WB.
  - Simultaneous cnt_clr and a retire: result is 0.
- stall_mem==1 together with stall_wb==1 is the hold case.
- No combinational path from any input to any output.

Decomposition:
- Shared package/defines gains the constants RstEnable_n=1'b0, ChGpr=0, ChHiLo=1, and the stall-vector bit indices.
- One natural sub-module: wb_chan_reg, a single-channel AW+DW+1-bit register with hold/clear/load controls.
  - Instantiated NCH times via generate.
  - The top level holds only the valid bit, the control decode and the counter.

Test Plan:
1. Reset: rst=0 for 2 cycles with arbitrary inputs → all outputs 0, retired=0. Then rst=1 → first load visible after 1 edge.
2. Advance on two channels:
   - Stimulus: mem_valid=1, ch0 wd=5'd3, data=32'hDEAD_BEEF, wreg=1; ch1 wd=5'd1, data=32'h0000_0010, wreg=1.
   - Response: next cycle, wb outputs match the inputs, wb_wreg=2'b11, wb_valid=1. retired becomes 1 one cycle later.
3. Bubble: stall_mem=1, stall_wb=0 while MEM holds ch0 wd=7 → wb_wreg=0, wb_valid=0, and retired does not increment for the bubble cycle.
4. Hold:
   - Stimulus: WB holds ch0 wd=9, data=32'h1234; apply stall_wb=1 for 3 cycles while changing the MEM inputs.
   - Response: wb outputs stay constant and retired is unchanged. After the stall releases, the new MEM value loads and retired +1.
5. Flush over stall: flush=1 with stall_wb=1 and wb_valid=1 → next cycle wb_valid=0, wb_wreg=0.
6. Counter edges:
   - Preload near the top with CNTW=4 (retired=4'hF), then one retirement → 4'h0.
   - cnt_clr=1 coincident with a retirement → 0.
   - mem_valid=0 with mem_wreg=1 → wb_wreg=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and control decode for the MEM->WB pipeline register.
// Holds the reset level, channel indices, stall-vector bit positions and the per-channel control enum.
package mem_wb_stage_pkg;

  localparam logic RstEnable_n = 1'b0;

  localparam int ChGpr  = 0;
  localparam int ChHiLo = 1;

  // Bit positions inside the core's 6-bit stall vector.
  localparam int StallPc   = 0;
  localparam int StallIf   = 1;
  localparam int StallId   = 2;
  localparam int StallEx   = 3;
  localparam int StallMem  = 4;
  localparam int StallWb   = 5;
  localparam int StallVecW = 6;

  typedef enum logic [1:0] {
    CTL_LOAD  = 2'd0,
    CTL_HOLD  = 2'd1,
    CTL_CLEAR = 2'd2
  } wb_ctl_e;

  // Priority is flush > WB stall (hold) > MEM-only stall (bubble) > advance.
  function automatic wb_ctl_e wb_ctl_decode(input logic flush,
                                            input logic stall_mem,
                                            input logic stall_wb);
    if (flush)     return CTL_CLEAR;
    if (stall_wb)  return CTL_HOLD;
    if (stall_mem) return CTL_CLEAR;
    return CTL_LOAD;
  endfunction

endpackage

// File: rtl/mem_wb_stage_chan.sv
// Single write-channel register (address, enable, data) with load/hold/clear control.
// One instance per channel; every channel is fully independent of the others.
module wb_chan_reg
  import mem_wb_stage_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  wb_ctl_e       i_ctl,
  input  logic [AW-1:0] i_wd,
  input  logic          i_wreg,
  input  logic [DW-1:0] i_wdata,
  output logic [AW-1:0] o_wd,
  output logic          o_wreg,
  output logic [DW-1:0] o_wdata
);

  logic [AW-1:0] r_wd;
  logic          r_wreg;
  logic [DW-1:0] r_wdata;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (i_ctl)
        CTL_LOAD: begin
          r_wd    <= i_wd;
          r_wreg  <= i_wreg;
          r_wdata <= i_wdata;
        end
        CTL_CLEAR: begin
          r_wd    <= '0;
          r_wreg  <= 1'b0;
          r_wdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_wd    = r_wd;
  assign o_wreg  = r_wreg;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with NCH independent write channels, stall/flush/bubble handling
// and a retired-instruction counter. All outputs come straight from registers.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int NCH  = 2,
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [NCH*AW-1:0] mem_wd,
  input  logic [NCH-1:0]    mem_wreg,
  input  logic [NCH*DW-1:0] mem_wdata,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic              wb_valid,
  output logic [NCH*AW-1:0] wb_wd,
  output logic [NCH-1:0]    wb_wreg,
  output logic [NCH*DW-1:0] wb_wdata,
  output logic [CNTW-1:0]   retired
);

  wb_ctl_e         w_ctl;
  logic            r_valid;
  logic [CNTW-1:0] r_retired;
  logic            w_retire;

  assign w_ctl = wb_ctl_decode(flush, stall_mem, stall_wb);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    wb_chan_reg #(
      .AW (AW),
      .DW (DW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .i_ctl   (w_ctl),
      .i_wd    (mem_wd[k*AW +: AW]),
      .i_wreg  (mem_wreg[k] & mem_valid),
      .i_wdata (mem_wdata[k*DW +: DW]),
      .o_wd    (wb_wd[k*AW +: AW]),
      .o_wreg  (wb_wreg[k]),
      .o_wdata (wb_wdata[k*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      r_valid <= 1'b0;
    end else begin
      case (w_ctl)
        CTL_LOAD:  r_valid <= mem_valid;
        CTL_CLEAR: r_valid <= 1'b0;
        default:   ;
      endcase
    end
  end

  // The instruction in WB retires whenever WB is not stalled, even if a flush arrives on the same edge.
  assign w_retire = r_valid & ~stall_wb;

  always_ff @(posedge clk) begin
    if (rst == RstEnable_n) begin
      r_retired <= '0;
    end else if (cnt_clr) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNTW'(1);
    end
  end

  assign wb_valid = r_valid;
  assign retired  = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: each step drives MEM inputs, pushes the expected WB state
// to a scoreboard queue, clocks once and pops/compares on the following falling edge.
module tb_mem_wb_stage;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NCH  = 2;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_valid;
  logic [NCH*AW-1:0] mem_wd;
  logic [NCH-1:0]    mem_wreg;
  logic [NCH*DW-1:0] mem_wdata;
  logic              stall_mem;
  logic              stall_wb;
  logic              flush;
  logic              cnt_clr;
  logic              wb_valid;
  logic [NCH*AW-1:0] wb_wd;
  logic [NCH-1:0]    wb_wreg;
  logic [NCH*DW-1:0] wb_wdata;
  logic [CNTW-1:0]   retired;

  mem_wb_stage #(
    .DW   (DW),
    .AW   (AW),
    .NCH  (NCH),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .stall_mem (stall_mem),
    .stall_wb  (stall_wb),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .wb_valid  (wb_valid),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              valid;
    logic [NCH*AW-1:0] wd;
    logic [NCH-1:0]    wreg;
    logic [NCH*DW-1:0] wdata;
    logic [CNTW-1:0]   ret;
  } exp_t;

  exp_t sb[$];
  exp_t model;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge WB state, clock, then compare.
  task automatic step(input logic v, input logic [NCH*AW-1:0] wd, input logic [NCH-1:0] wr,
                      input logic [NCH*DW-1:0] wdat, input logic smem, input logic swb,
                      input logic fl, input logic clr, input logic rstv);
    exp_t e;
    exp_t got;
    rst = rstv; mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
    stall_mem = smem; stall_wb = swb; flush = fl; cnt_clr = clr;
    e = model;
    if (!rstv)                    e.ret = '0;
    else if (clr)                 e.ret = '0;
    else if (model.valid && !swb) e.ret = model.ret + 4'd1;
    if (!rstv || fl || (smem && !swb)) begin
      e.valid = 1'b0; e.wd = '0; e.wreg = '0; e.wdata = '0;
    end else if (!swb) begin
      e.valid = v; e.wd = wd; e.wreg = wr & {NCH{v}}; e.wdata = wdat;
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    check("wb_valid", 64'(wb_valid), 64'(got.valid));
    check("wb_wd",    64'(wb_wd),    64'(got.wd));
    check("wb_wreg",  64'(wb_wreg),  64'(got.wreg));
    check("wb_wdata", wb_wdata,      got.wdata);
    check("retired",  64'(retired),  64'(got.ret));
    model = got;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model = '{valid: 1'b0, wd: '0, wreg: '0, wdata: '0, ret: '0};

    // Reset with non-zero inputs, twice.
    step(1'b1, {5'd31, 5'd17}, 2'b11, {32'hFFFF_0000, 32'hCAFE_F00D}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, {5'd2, 5'd4}, 2'b11, {32'h1, 32'h2}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("reset_retired", 64'(retired), 64'd0);

    // Advance on both channels; first load visible after one edge.
    step(1'b1, {5'd1, 5'd3}, 2'b11, {32'h0000_0010, 32'hDEAD_BEEF}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("adv_wreg", 64'(wb_wreg), 64'h3);
    check("adv_ch0_data", 64'(wb_wdata[31:0]), 64'hDEAD_BEEF);
    check("adv_ch1_wd", 64'(wb_wd[9:5]), 64'd1);
    check("adv_retired0", 64'(retired), 64'd0);
    step(1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h7777_7777}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("adv_retired1", 64'(retired), 64'd1);

    // Bubble while MEM still holds ch0 wd=7: the valid WB entry retires, then bubbles do not count.
    step(1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h7777_7777}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bubble_valid", 64'(wb_valid), 64'd0);
    check("bubble_wreg", 64'(wb_wreg), 64'd0);
    step(1'b1, {5'd0, 5'd7}, 2'b01, {32'h0, 32'h7777_7777}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bubble_retired", 64'(retired), 64'd2);

    // Hold: load ch0 wd=9, then stall WB for three cycles with changing MEM inputs.
    step(1'b1, {5'd0, 5'd9}, 2'b01, {32'h0, 32'h0000_1234}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, {5'(i + 20), 5'(i + 10)}, 2'b11, {32'(i) * 32'h1111, 32'hA5A5_0000 + 32'(i)},
           i[0], 1'b1, 1'b0, 1'b0, 1'b1);
    check("hold_wd", 64'(wb_wd[4:0]), 64'd9);
    check("hold_data", 64'(wb_wdata[31:0]), 64'h1234);
    check("hold_retired", 64'(retired), 64'd2);
    step(1'b1, {5'd5, 5'd6}, 2'b10, {32'h5555_5555, 32'h6666_6666}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("release_retired", 64'(retired), 64'd3);

    // Flush overrides stall_wb; the stalled entry is killed, not retired.
    step(1'b1, {5'd8, 5'd8}, 2'b11, {32'h8, 32'h8}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("flush_valid", 64'(wb_valid), 64'd0);
    check("flush_retired", 64'(retired), 64'd3);
    // Flush without a stall still retires the instruction leaving WB.
    step(1'b1, {5'd2, 5'd2}, 2'b11, {32'h2, 32'h2}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, {5'd3, 5'd3}, 2'b11, {32'h3, 32'h3}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("flush_retire", 64'(retired), 64'd4);

    // Counter: clear, count up to 4'hF, wrap to 0.
    step(1'b1, {5'd0, 5'd1}, 2'b01, {32'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++)
      step(1'b1, {5'd0, 5'(i)}, 2'b01, {32'h0, 32'(i)}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("cnt_top", 64'(retired), 64'hF);
    step(1'b1, {5'd0, 5'd1}, 2'b01, {32'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("cnt_wrap", 64'(retired), 64'h0);
    step(1'b1, {5'd0, 5'd1}, 2'b01, {32'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, {5'd0, 5'd1}, 2'b01, {32'h0, 32'h1}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("cnt_clr_vs_retire", 64'(retired), 64'h0);

    // Invalid MEM entry with enables set must not write.
    step(1'b0, {5'd4, 5'd4}, 2'b11, {32'h4, 32'h4}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("invalid_wreg", 64'(wb_wreg), 64'd0);

    // Reset mid-operation discards the in-flight entry.
    step(1'b1, {5'd12, 5'd13}, 2'b11, {32'hBEEF, 32'hF00D}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, {5'd14, 5'd15}, 2'b11, {32'h1, 32'h2}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midreset_valid", 64'(wb_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
